local_mport_arbiter: RTL and testbench



---
 rtl/local_mport_arbiter_pkg.sv | 24 ++
 rtl/local_mport_tag_fifo.sv | 55 +++++
 rtl/local_mport_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_local_mport_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/local_mport_arbiter_pkg.sv
// Shared types for the multi-port local-interface arbiter: FSM states, read-return tag and sizing.
package local_mport_arbiter_pkg;

  localparam int MAX_PORTS  = 8;
  localparam int PORT_W     = $clog2(MAX_PORTS);
  localparam int TAG_SIZE_W = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WR_BURST = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic [PORT_W-1:0]     port;
    logic [TAG_SIZE_W-1:0] size;
  } tag_t;

  // A zero-length burst still moves one beat.
  function automatic logic [TAG_SIZE_W-1:0] eff_size(input logic [TAG_SIZE_W-1:0] size);
    return (size == {TAG_SIZE_W{1'b0}}) ? TAG_SIZE_W'(1'b1) : size;
  endfunction

endpackage

// File: rtl/local_mport_tag_fifo.sv
// Show-ahead FIFO of read tags; the head entry names the port owed the next return beats.
module local_mport_tag_fifo
  import local_mport_arbiter_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  tag_t push_data,
  input  logic pop,
  output tag_t head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  tag_t             mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];

  // Pointers wrap naturally; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Tag storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/local_mport_arbiter.sv
// Round-robin front end sharing one controller local interface among NUM_PORTS masters,
// with write-burst locking and in-order read-data steering.
module local_mport_arbiter
  import local_mport_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int BE_W      = DATA_W / 8,
  parameter int SIZE_W    = TAG_SIZE_W,
  parameter int RDQ_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_address,
  input  logic [NUM_PORTS-1:0]        port_read_req,
  input  logic [NUM_PORTS-1:0]        port_write_req,
  input  logic [NUM_PORTS-1:0]        port_burstbegin,
  input  logic [NUM_PORTS*SIZE_W-1:0] port_size,
  input  logic [NUM_PORTS*BE_W-1:0]   port_be,
  input  logic [NUM_PORTS*DATA_W-1:0] port_wdata,
  output logic [NUM_PORTS-1:0]        port_ready,
  output logic [DATA_W-1:0]           port_rdata,
  output logic [NUM_PORTS-1:0]        port_rdata_valid,
  input  logic                        local_init_done,
  input  logic                        local_ready,
  input  logic [DATA_W-1:0]           local_rdata,
  input  logic                        local_rdata_valid,
  output logic [ADDR_W-1:0]           local_address,
  output logic                        local_read_req,
  output logic                        local_write_req,
  output logic                        local_burstbegin,
  output logic [SIZE_W-1:0]           local_size,
  output logic [BE_W-1:0]             local_be,
  output logic [DATA_W-1:0]           local_wdata,
  output logic                        err_protocol,
  output logic                        err_orphan_rdata
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  fsm_state_t              state_r, state_next_s;
  logic [IDX_W-1:0]        gnt_r, gnt_next_s, rr_r, rr_next_s, pick_s;
  logic [SIZE_W-1:0]       beat_r, beat_next_s, bsize_r, bsize_next_s;
  logic [TAG_SIZE_W-1:0]   rbeat_r;
  logic [NUM_PORTS-1:0]    any_req_s, gnt_onehot_s;
  logic [2*NUM_PORTS-1:0]  req_dbl_s;
  logic                    pick_valid_s;
  logic                    sel_rd_s, sel_wr_s, sel_bb_s, rd_only_s;
  logic [ADDR_W-1:0]       sel_addr_s;
  logic [SIZE_W-1:0]       sel_size_s, sel_eff_s;
  logic [BE_W-1:0]         sel_be_s;
  logic [DATA_W-1:0]       sel_wdata_s;
  logic                    fifo_push_s, fifo_pop_s, fifo_full_s, fifo_empty_s, rd_hit_s;
  tag_t                    push_tag_s, head_s;

  assign any_req_s = port_read_req | port_write_req;
  assign rd_only_s = sel_rd_s && !sel_wr_s;
  assign sel_eff_s = eff_size(sel_size_s);

  // First requester strictly after the round-robin pointer, found on a doubled request vector.
  always_comb begin
    req_dbl_s    = {any_req_s, any_req_s} >> (int'(rr_r) + 1);
    pick_valid_s = |any_req_s;
    pick_s       = rr_r;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      pick_s = req_dbl_s[j] ? IDX_W'((int'(rr_r) + 1 + j) % NUM_PORTS) : pick_s;
    end
  end

  // AND-OR mux of the granted port's command fields.
  always_comb begin
    gnt_onehot_s = {NUM_PORTS{1'b0}};
    sel_rd_s = 1'b0;  sel_wr_s = 1'b0;  sel_bb_s = 1'b0;
    sel_addr_s = {ADDR_W{1'b0}};  sel_size_s = {SIZE_W{1'b0}};
    sel_be_s = {BE_W{1'b0}};      sel_wdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      gnt_onehot_s[i] = (gnt_r == IDX_W'(i));
      sel_rd_s    |= port_read_req[i] & gnt_onehot_s[i];
      sel_wr_s    |= port_write_req[i] & gnt_onehot_s[i];
      sel_bb_s    |= port_burstbegin[i] & gnt_onehot_s[i];
      sel_addr_s  |= port_address[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_onehot_s[i]}};
      sel_size_s  |= port_size[i*SIZE_W +: SIZE_W] & {SIZE_W{gnt_onehot_s[i]}};
      sel_be_s    |= port_be[i*BE_W +: BE_W] & {BE_W{gnt_onehot_s[i]}};
      sel_wdata_s |= port_wdata[i*DATA_W +: DATA_W] & {DATA_W{gnt_onehot_s[i]}};
    end
  end

  // FSM state, grant, pointer and burst bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      gnt_r   <= {IDX_W{1'b0}};
      rr_r    <= IDX_W'(NUM_PORTS - 1);
      beat_r  <= {SIZE_W{1'b0}};
      bsize_r <= {SIZE_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      gnt_r   <= gnt_next_s;
      rr_r    <= rr_next_s;
      beat_r  <= beat_next_s;
      bsize_r <= bsize_next_s;
    end
  end

  // Next-state logic; a write wins over a read raised together on the granted port.
  always_comb begin
    state_next_s = state_r;
    gnt_next_s   = gnt_r;
    rr_next_s    = rr_r;
    beat_next_s  = beat_r;
    bsize_next_s = bsize_r;
    case (state_r)
      IDLE: begin
        if (local_init_done && pick_valid_s) begin
          gnt_next_s   = pick_s;
          state_next_s = GRANT;
        end else begin
          state_next_s = IDLE;
        end
      end
      GRANT: begin
        if (sel_wr_s) begin
          if (local_ready && (sel_eff_s > SIZE_W'(1'b1))) begin
            beat_next_s  = sel_eff_s - SIZE_W'(1'b1);
            bsize_next_s = sel_size_s;
            state_next_s = WR_BURST;
          end else if (local_ready) begin
            rr_next_s    = gnt_r;
            state_next_s = IDLE;
          end else begin
            state_next_s = GRANT;
          end
        end else if (sel_rd_s) begin
          if (local_ready && !fifo_full_s) begin
            rr_next_s    = gnt_r;
            state_next_s = IDLE;
          end else begin
            state_next_s = GRANT;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      WR_BURST: begin
        if (sel_wr_s && local_ready && (beat_r == SIZE_W'(1'b1))) begin
          rr_next_s    = gnt_r;
          state_next_s = IDLE;
        end else if (sel_wr_s && local_ready) begin
          beat_next_s  = beat_r - SIZE_W'(1'b1);
        end else begin
          state_next_s = WR_BURST;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Local command outputs and per-port ready, driven from the granted port.
  always_comb begin
    local_address    = {ADDR_W{1'b0}};
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    local_size       = {SIZE_W{1'b0}};
    local_be         = {BE_W{1'b0}};
    local_wdata      = {DATA_W{1'b0}};
    port_ready       = {NUM_PORTS{1'b0}};
    case (state_r)
      GRANT: begin
        local_address    = sel_addr_s;
        local_read_req   = rd_only_s && !fifo_full_s;
        local_write_req  = sel_wr_s;
        local_burstbegin = sel_bb_s;
        local_size       = sel_size_s;
        local_be         = sel_be_s;
        local_wdata      = sel_wdata_s;
        port_ready       = gnt_onehot_s &
                           {NUM_PORTS{local_ready && (sel_wr_s || (sel_rd_s && !fifo_full_s))}};
      end
      WR_BURST: begin
        local_address    = sel_addr_s;
        local_write_req  = sel_wr_s;
        local_size       = bsize_r;
        local_be         = sel_be_s;
        local_wdata      = sel_wdata_s;
        port_ready       = gnt_onehot_s & {NUM_PORTS{local_ready && sel_wr_s}};
      end
      default: port_ready = {NUM_PORTS{1'b0}};
    endcase
  end

  assign fifo_push_s = (state_r == GRANT) && rd_only_s && local_ready && !fifo_full_s;
  assign push_tag_s  = '{port: PORT_W'(gnt_r), size: sel_size_s};
  assign rd_hit_s    = local_rdata_valid && !fifo_empty_s;
  assign fifo_pop_s  = rd_hit_s && (rbeat_r == (eff_size(head_s.size) - TAG_SIZE_W'(1'b1)));

  local_mport_tag_fifo #(.DEPTH(RDQ_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data (push_tag_s),
    .pop       (fifo_pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Zero-latency steering of returning read data to the head tag's port.
  always_comb begin
    port_rdata_valid = {NUM_PORTS{1'b0}};
    port_rdata       = rd_hit_s ? local_rdata : {DATA_W{1'b0}};
    for (int i = 0; i < NUM_PORTS; i++) begin
      port_rdata_valid[i] = rd_hit_s && (head_s.port == PORT_W'(i));
    end
  end

  // Return-beat counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rbeat_r          <= {TAG_SIZE_W{1'b0}};
      err_protocol     <= 1'b0;
      err_orphan_rdata <= 1'b0;
    end else begin
      if (fifo_pop_s)    rbeat_r <= {TAG_SIZE_W{1'b0}};
      else if (rd_hit_s) rbeat_r <= rbeat_r + TAG_SIZE_W'(1'b1);
      if (|(port_read_req & port_write_req))     err_protocol     <= 1'b1;
      if (local_rdata_valid && fifo_empty_s)     err_orphan_rdata <= 1'b1;
    end
  end

endmodule

// File: tb/tb_local_mport_arbiter.sv
// Randomized traffic checked against a transaction-level round-robin model, plus directed
// FIFO-full, error-flag and mid-burst reset scenarios.
module tb_local_mport_arbiter;

  localparam int NP = 4, AW = 24, DW = 16, BW = 2, SW = 3, NT = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NP*AW-1:0] port_address;
  logic [NP-1:0]    port_read_req, port_write_req, port_burstbegin, port_ready, port_rdata_valid;
  logic [NP*SW-1:0] port_size;
  logic [NP*BW-1:0] port_be;
  logic [NP*DW-1:0] port_wdata;
  logic [DW-1:0]    port_rdata, local_rdata, local_wdata;
  logic             local_init_done, local_ready, local_rdata_valid;
  logic [AW-1:0]    local_address;
  logic             local_read_req, local_write_req, local_burstbegin;
  logic [SW-1:0]    local_size;
  logic [BW-1:0]    local_be;
  logic             err_protocol, err_orphan_rdata;

  logic [AW-1:0] m_addr [NP];
  logic          m_rd [NP], m_wr [NP], m_bb [NP];
  logic [SW-1:0] m_size [NP];
  logic [DW-1:0] m_wdata [NP];

  always_comb begin
    for (int i = 0; i < NP; i++) begin
      port_address[i*AW +: AW] = m_addr[i];
      port_read_req[i]         = m_rd[i];
      port_write_req[i]        = m_wr[i];
      port_burstbegin[i]       = m_bb[i];
      port_size[i*SW +: SW]    = m_size[i];
      port_be[i*BW +: BW]      = 2'b11;
      port_wdata[i*DW +: DW]   = m_wdata[i];
    end
  end

  local_mport_arbiter dut (
    .clk(clk), .reset(reset),
    .port_address(port_address), .port_read_req(port_read_req), .port_write_req(port_write_req),
    .port_burstbegin(port_burstbegin), .port_size(port_size), .port_be(port_be),
    .port_wdata(port_wdata), .port_ready(port_ready), .port_rdata(port_rdata),
    .port_rdata_valid(port_rdata_valid), .local_init_done(local_init_done),
    .local_ready(local_ready), .local_rdata(local_rdata), .local_rdata_valid(local_rdata_valid),
    .local_address(local_address), .local_read_req(local_read_req),
    .local_write_req(local_write_req), .local_burstbegin(local_burstbegin),
    .local_size(local_size), .local_be(local_be), .local_wdata(local_wdata),
    .err_protocol(err_protocol), .err_orphan_rdata(err_orphan_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Per-port transaction lists and progress.
  logic          t_wr   [NP][NT];
  logic [SW-1:0] t_size [NP][NT];
  logic [AW-1:0] t_addr [NP][NT];
  logic [DW-1:0] t_data [NP][NT];
  int            t_idx  [NP];
  int            t_beat [NP];

  function automatic int eff(input logic [SW-1:0] s);
    return (s == 3'd0) ? 1 : int'(s);
  endfunction

  function automatic int next_port(input int rr);
    for (int k = 1; k <= NP; k++) begin
      if (t_idx[(rr + k) % NP] < NT) return (rr + k) % NP;
    end
    return -1;
  endfunction

  task automatic clear_masters();
    for (int p = 0; p < NP; p++) begin
      m_addr[p] = 24'd0; m_rd[p] = 1'b0; m_wr[p] = 1'b0; m_bb[p] = 1'b0;
      m_size[p] = 3'd0;  m_wdata[p] = 16'd0;
    end
  endtask

  task automatic set_masters();
    clear_masters();
    for (int p = 0; p < NP; p++) begin
      if (t_idx[p] < NT) begin
        m_rd[p]    = !t_wr[p][t_idx[p]];
        m_wr[p]    = t_wr[p][t_idx[p]];
        m_bb[p]    = (t_beat[p] == 0);
        m_size[p]  = t_size[p][t_idx[p]];
        m_addr[p]  = t_addr[p][t_idx[p]];
        m_wdata[p] = t_data[p][t_idx[p]] + DW'(t_beat[p]);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic random_phase();
    int model_rr = NP - 1, cur = 0, left = 0, last_end = -10, nxt, p, exp_port;
    int rq[$];
    bit all_done = 1'b0;
    for (int cyc = 0; cyc < 5000 && !(all_done && rq.size() == 0); cyc++) begin
      set_masters();
      local_ready       = ($urandom_range(0, 3) != 0);
      local_rdata_valid = (rq.size() > 0) && ($urandom_range(0, 2) == 0);
      local_rdata       = 16'($urandom);
      @(negedge clk);
      if (local_rdata_valid) begin
        exp_port = rq.pop_front();
        check_eq("rd_route", port_rdata_valid, 64'(1) << exp_port);
        check_eq("rd_data", port_rdata, local_rdata);
      end else begin
        check_eq("rd_idle", port_rdata_valid, 0);
      end
      if (port_ready != 4'd0) begin
        if (left == 0) begin
          nxt = next_port(model_rr);
          if (nxt < 0) begin
            check_eq("spurious_ready", port_ready, 0);
          end else begin
            cur  = nxt;
            left = t_wr[cur][t_idx[cur]] ? eff(t_size[cur][t_idx[cur]]) : 1;
            check_eq("gnt_port", port_ready, 64'(1) << cur);
            check_eq("bubble", (cyc - last_end >= 2) ? 1 : 0, 1);
            check_eq("gnt_addr", local_address, t_addr[cur][t_idx[cur]]);
            check_eq("gnt_rd", local_read_req, !t_wr[cur][t_idx[cur]]);
            if (!t_wr[cur][t_idx[cur]]) begin
              for (int b = 0; b < eff(t_size[cur][t_idx[cur]]); b++) rq.push_back(cur);
            end
          end
        end else begin
          check_eq("burst_port", port_ready, 64'(1) << cur);
        end
        if (left > 0) begin
          p = cur;
          check_eq("cmd_size", local_size, t_size[p][t_idx[p]]);
          check_eq("cmd_bb", local_burstbegin, (t_beat[p] == 0) ? 1 : 0);
          if (t_wr[p][t_idx[p]]) begin
            check_eq("wr_req", local_write_req, 1);
            check_eq("wr_data", local_wdata, t_data[p][t_idx[p]] + DW'(t_beat[p]));
          end
          left--;
          t_beat[p]++;
          if (left == 0) begin
            t_idx[p]++;
            t_beat[p] = 0;
            model_rr  = p;
            last_end  = cyc;
          end
        end
      end
      all_done = (next_port(0) < 0);
      @(posedge clk);
      #1;
    end
    check_eq("traffic_done", (all_done && rq.size() == 0) ? 1 : 0, 1);
    local_rdata_valid = 1'b0;
  endtask

  int n;

  initial begin
    reset = 1'b1; local_init_done = 1'b0; local_ready = 1'b0;
    local_rdata_valid = 1'b0; local_rdata = 16'h0;
    clear_masters();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", port_ready, 0);
    check_eq("rst_req", {local_read_req, local_write_req}, 0);
    check_eq("rst_addr", local_address, 0);
    check_eq("rst_err", {err_protocol, err_orphan_rdata}, 0);
    reset = 1'b0;

    for (int p = 0; p < NP; p++) begin
      t_idx[p] = 0; t_beat[p] = 0;
      for (int t = 0; t < NT; t++) begin
        t_wr[p][t]   = 1'($urandom_range(0, 1));
        t_size[p][t] = 3'($urandom_range(0, 4));
        t_addr[p][t] = 24'($urandom);
        t_data[p][t] = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    set_masters();
    local_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("nocal_ready", port_ready, 0);
      check_eq("nocal_req", {local_read_req, local_write_req}, 0);
    end
    @(posedge clk); #1;
    local_init_done = 1'b1;
    random_phase();
    check_eq("rand_err", {err_protocol, err_orphan_rdata}, 0);

    // Fill the tag FIFO with 16 single-beat reads and confirm the 17th stalls.
    do_reset();
    clear_masters();
    m_rd[0] = 1'b1; m_size[0] = 3'd1; m_bb[0] = 1'b1; m_addr[0] = 24'h001234;
    local_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 200 && n < 16; c++) begin
      @(negedge clk);
      if (port_ready[0]) n++;
      @(posedge clk); #1;
    end
    check_eq("fill_count", n, 16);
    repeat (4) begin
      @(negedge clk);
      check_eq("full_stall_req", local_read_req, 0);
      check_eq("full_stall_rdy", port_ready, 0);
      @(posedge clk); #1;
    end
    local_rdata_valid = 1'b1; local_rdata = 16'hBEEF;
    @(negedge clk);
    check_eq("ret_valid", port_rdata_valid, 4'b0001);
    check_eq("ret_data", port_rdata, 16'hBEEF);
    @(posedge clk); #1;
    local_rdata_valid = 1'b0;
    @(negedge clk);
    check_eq("unstall_req", local_read_req, 1);
    check_eq("unstall_rdy", port_ready, 4'b0001);
    @(posedge clk); #1;
    m_rd[0] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      local_rdata_valid = 1'b1; local_rdata = 16'(i);
      @(negedge clk);
      check_eq("drain_valid", port_rdata_valid, 4'b0001);
      @(posedge clk); #1;
    end
    local_rdata_valid = 1'b0;

    // Orphan return beat with an empty tag FIFO.
    local_rdata_valid = 1'b1;
    @(negedge clk);
    check_eq("orphan_route", port_rdata_valid, 0);
    check_eq("orphan_pre", err_orphan_rdata, 0);
    @(posedge clk); #1;
    local_rdata_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("orphan_sticky", err_orphan_rdata, 1);
      @(posedge clk); #1;
    end
    check_eq("proto_pre", err_protocol, 0);

    // Read and write raised together.
    m_rd[1] = 1'b1; m_wr[1] = 1'b1; m_size[1] = 3'd1; m_bb[1] = 1'b1;
    @(posedge clk); #1;
    clear_masters();
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("proto_sticky", err_protocol, 1);

    // Reset at beat 2 of a 4-beat write from port 2.
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check_eq("rst2_err", {err_protocol, err_orphan_rdata}, 0);
    @(posedge clk); #1;
    m_wr[2] = 1'b1; m_size[2] = 3'd4; m_bb[2] = 1'b1; m_addr[2] = 24'hABCDEF; m_wdata[2] = 16'h2000;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk);
      if (port_ready != 4'd0) begin
        check_eq("burst_rdy", port_ready, 4'b0100);
        check_eq("burst_bb", local_burstbegin, (n == 0) ? 1 : 0);
        n++;
      end
      @(posedge clk); #1;
      if (n > 0) begin
        m_bb[2] = 1'b0;
        m_wr[0] = 1'b1; m_size[0] = 3'd1; m_bb[0] = 1'b1;
      end
    end
    check_eq("burst_beats", n, 2);
    reset = 1'b1; local_rdata = 16'h5A5A;
    @(posedge clk);
    @(negedge clk);
    check_eq("mid_rst_ready", port_ready, 0);
    check_eq("mid_rst_req", {local_read_req, local_write_req, local_burstbegin}, 0);
    check_eq("mid_rst_addr", local_address, 0);
    check_eq("mid_rst_wdata", local_wdata, 0);
    check_eq("mid_rst_rdata", {port_rdata, port_rdata_valid}, 0);
    @(posedge clk); #1;
    reset = 1'b0; m_bb[2] = 1'b1;
    n = -1;
    for (int c = 0; c < 20 && n < 0; c++) begin
      @(negedge clk);
      if (port_ready != 4'd0) n = int'(port_ready);
      @(posedge clk); #1;
    end
    check_eq("restart_port0", n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
